sd_stream_scheduler: RTL

Sequences multi-sector reads from the SPI-mode SD controller and streams the bytes into the audio sample FIFO. It accepts clip playback requests from the keyboard front end as a start address and a sector count. It issues one sector read at a time, and only when the FIFO has room for a full sector. It supports a stop command and request pre-emption at sector boundaries, and flags a stalled card with a timeout.

---
 rtl/sd_stream_scheduler.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/sd_stream_scheduler.sv
`timescale 1ns/1ps
// sd_stream_scheduler
//   Plays audio clips stored on an SPI-mode SD card. A clip request (start
//   byte address + sector count) is turned into a series of single-sector
//   reads. Every byte the controller delivers is forwarded to the sample FIFO.
//   A new sector read is started only when the FIFO has room for a whole
//   sector. Stop commands and new requests take effect at sector boundaries.
//   A card that stops delivering bytes is abandoned after TIMEOUT_CYC cycles.
//
// Ports
//   clk_100mhz, reset_n          system clock, synchronous active-low reset
//   req_valid/req_addr/req_sectors  clip request (one-cycle pulse)
//   stop                         end the clip after the current sector
//   sd_ready, sd_byte_available, sd_dout   SD controller status / read data
//   sd_rd, sd_addr               SD controller read command
//   fifo_count                   FIFO occupancy in bytes
//   fifo_wr, fifo_din            FIFO write port
//   busy, done, err_timeout, sectors_left  clip status
module sd_stream_scheduler #(
    parameter int unsigned SECTOR_BYTES = 512,
    parameter int unsigned FIFO_DEPTH   = 2048,
    parameter int unsigned CNT_W        = 11,
    parameter int unsigned TIMEOUT_CYC  = 2000000
) (
    input  logic             clk_100mhz,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic [31:0]      req_addr,
    input  logic [15:0]      req_sectors,
    input  logic             stop,
    input  logic             sd_ready,
    input  logic             sd_byte_available,
    input  logic [7:0]       sd_dout,
    output logic             sd_rd,
    output logic [31:0]      sd_addr,
    input  logic [CNT_W-1:0] fifo_count,
    output logic             fifo_wr,
    output logic [7:0]       fifo_din,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic [15:0]      sectors_left
);

    localparam int unsigned BC_W = $clog2(SECTOR_BYTES);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BC_W-1:0] LAST_BYTE   = BC_W'(SECTOR_BYTES - 1);
    localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [31:0]     SPACE_LIMIT = 32'(FIFO_DEPTH - SECTOR_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SPACE,
        STREAM,
        BOUNDARY
    } state_t;

    state_t          state, state_n;
    logic            byte_prev;
    logic            byte_edge;
    logic            has_space;

    logic            sd_rd_n;
    logic [31:0]     sd_addr_n;
    logic            fifo_wr_n;
    logic [7:0]      fifo_din_n;
    logic            busy_n;
    logic            done_n;
    logic            err_timeout_n;
    logic [15:0]     sectors_left_n;

    logic            pend_valid, pend_valid_n;
    logic [31:0]     pend_addr, pend_addr_n;
    logic [15:0]     pend_sectors, pend_sectors_n;
    logic            stop_flag, stop_flag_n;
    logic [BC_W-1:0] byte_cnt, byte_cnt_n;
    logic [TO_W-1:0] to_cnt, to_cnt_n;

    // The byte strobe comes from the slower SD clock domain as a level.
    assign byte_edge = sd_byte_available & ~byte_prev;
    assign has_space = (32'(fifo_count) <= SPACE_LIMIT);

    always_comb begin
        state_n        = state;
        sd_rd_n        = sd_rd;
        sd_addr_n      = sd_addr;
        fifo_wr_n      = 1'b0;
        fifo_din_n     = fifo_din;
        busy_n         = busy;
        done_n         = 1'b0;
        err_timeout_n  = err_timeout;
        sectors_left_n = sectors_left;
        pend_valid_n   = pend_valid;
        pend_addr_n    = pend_addr;
        pend_sectors_n = pend_sectors;
        stop_flag_n    = stop_flag;
        byte_cnt_n     = byte_cnt;
        to_cnt_n       = to_cnt;

        case (state)
            IDLE: begin
                stop_flag_n = 1'b0;
                if (req_valid) begin
                    pend_valid_n = 1'b0;
                    if (req_sectors != '0) begin
                        sd_addr_n      = req_addr;
                        sectors_left_n = req_sectors;
                        busy_n         = 1'b1;
                        err_timeout_n  = 1'b0;
                        state_n        = WAIT_SPACE;
                    end else begin
                        done_n = 1'b1;
                    end
                end else if (pend_valid) begin
                    // A request that arrived on the clip's final cycle.
                    pend_valid_n   = 1'b0;
                    sd_addr_n      = pend_addr;
                    sectors_left_n = pend_sectors;
                    busy_n         = 1'b1;
                    err_timeout_n  = 1'b0;
                    state_n        = WAIT_SPACE;
                end
            end

            // WAIT_SPACE reacts to stop/pre-emption exactly like a boundary,
            // so no extra sector is fetched once either is pending.
            WAIT_SPACE, BOUNDARY: begin
                if (pend_valid) begin
                    pend_valid_n   = 1'b0;
                    stop_flag_n    = 1'b0;
                    sd_addr_n      = pend_addr;
                    sectors_left_n = pend_sectors;
                    state_n        = WAIT_SPACE;
                end else if (stop_flag || (sectors_left == '0)) begin
                    done_n         = 1'b1;
                    busy_n         = 1'b0;
                    sectors_left_n = '0;
                    stop_flag_n    = 1'b0;
                    state_n        = IDLE;
                end else if (state == WAIT_SPACE) begin
                    if (sd_ready && has_space) begin
                        sd_rd_n    = 1'b1;
                        byte_cnt_n = '0;
                        to_cnt_n   = '0;
                        state_n    = STREAM;
                    end
                end else begin
                    state_n = WAIT_SPACE;
                end
            end

            STREAM: begin
                if (!sd_ready) begin
                    sd_rd_n = 1'b0;
                end
                if (byte_edge) begin
                    fifo_wr_n  = 1'b1;
                    fifo_din_n = sd_dout;
                    to_cnt_n   = '0;
                    if (byte_cnt == LAST_BYTE) begin
                        sd_addr_n      = sd_addr + 32'(SECTOR_BYTES);
                        sectors_left_n = sectors_left - 16'd1;
                        sd_rd_n        = 1'b0;
                        state_n        = BOUNDARY;
                    end else begin
                        byte_cnt_n = byte_cnt + BC_W'(1);
                    end
                end else if (to_cnt == TO_LAST) begin
                    sd_rd_n        = 1'b0;
                    err_timeout_n  = 1'b1;
                    done_n         = 1'b1;
                    busy_n         = 1'b0;
                    sectors_left_n = '0;
                    state_n        = IDLE;
                end else begin
                    to_cnt_n = to_cnt + TO_W'(1);
                end
            end

            default: state_n = IDLE;
        endcase

        // Capture after the state actions so that a command arriving in the
        // same cycle a pending one is consumed is kept, not lost.
        if (state != IDLE) begin
            if (req_valid && (req_sectors != '0)) begin
                pend_valid_n   = 1'b1;
                pend_addr_n    = req_addr;
                pend_sectors_n = req_sectors;
                stop_flag_n    = 1'b0;
            end else if (req_valid || stop) begin
                stop_flag_n = 1'b1;
                if (req_valid) begin
                    pend_valid_n = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_100mhz) begin
        byte_prev <= sd_byte_available;
        if (!reset_n) begin
            state        <= IDLE;
            sd_rd        <= 1'b0;
            sd_addr      <= '0;
            fifo_wr      <= 1'b0;
            fifo_din     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_timeout  <= 1'b0;
            sectors_left <= '0;
            pend_valid   <= 1'b0;
            pend_addr    <= '0;
            pend_sectors <= '0;
            stop_flag    <= 1'b0;
            byte_cnt     <= '0;
            to_cnt       <= '0;
        end else begin
            state        <= state_n;
            sd_rd        <= sd_rd_n;
            sd_addr      <= sd_addr_n;
            fifo_wr      <= fifo_wr_n;
            fifo_din     <= fifo_din_n;
            busy         <= busy_n;
            done         <= done_n;
            err_timeout  <= err_timeout_n;
            sectors_left <= sectors_left_n;
            pend_valid   <= pend_valid_n;
            pend_addr    <= pend_addr_n;
            pend_sectors <= pend_sectors_n;
            stop_flag    <= stop_flag_n;
            byte_cnt     <= byte_cnt_n;
            to_cnt       <= to_cnt_n;
        end
    end

endmodule
